// File: rtl/seq_acc_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_acc_alu
// Description : Registered accumulator ALU. Holds the accumulator and the
//               carry flag internally, executes single-cycle ops (ADD, SUB,
//               AND, OR, XOR, LDA, SHL, SHR) and an iterative shift-add MUL
//               behind a start/ready/done handshake.
// Ports       : clk      - system clock, rising edge
//               rst      - asynchronous active-high reset
//               start    - execute opcode on operand (accepted when ready=1)
//               opcode   - 4-bit operation select
//               operand  - second operand (memory data bus)
//               ready    - 1 = idle, a start is accepted on this edge
//               done     - 1-cycle pulse, acc/carry hold the last result
//               acc      - accumulator register
//               is_zero  - combinational (acc == 0)
//               carry    - carry / borrow / multiply-overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module seq_acc_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] acc,
    output logic             is_zero,
    output logic             carry
);

    // Iteration counter width, derived from WIDTH.
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_LDA = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_MUL_RUN = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       acc_q, acc_d;
    logic                   carry_q, carry_d;
    logic                   done_q, done_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [WIDTH:0]         sum_w;
    logic [WIDTH:0]         diff_w;
    logic [2*WIDTH-1:0]     prod_next_w;

    // Extra MSB captures carry-out (ADD) or borrow (SUB).
    assign sum_w  = {1'b0, acc_q} + {1'b0, operand};
    assign diff_w = {1'b0, acc_q} - {1'b0, operand};

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set.
    assign prod_next_w = prod_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d = 1'b1;
                    case (opcode)
                        OP_ADD: begin
                            acc_d   = sum_w[WIDTH-1:0];
                            carry_d = sum_w[WIDTH];
                        end
                        OP_SUB: begin
                            acc_d   = diff_w[WIDTH-1:0];
                            carry_d = diff_w[WIDTH];
                        end
                        OP_AND: begin
                            acc_d   = acc_q & operand;
                            carry_d = 1'b0;
                        end
                        OP_OR: begin
                            acc_d   = acc_q | operand;
                            carry_d = 1'b0;
                        end
                        OP_XOR: begin
                            acc_d   = acc_q ^ operand;
                            carry_d = 1'b0;
                        end
                        OP_LDA: begin
                            acc_d   = operand;
                            carry_d = 1'b0;
                        end
                        OP_SHL: begin
                            acc_d   = {acc_q[WIDTH-2:0], 1'b0};
                            carry_d = acc_q[WIDTH-1];
                        end
                        OP_SHR: begin
                            acc_d   = {1'b0, acc_q[WIDTH-1:1]};
                            carry_d = acc_q[0];
                        end
                        OP_MUL: begin
                            // done is reported only when the product lands.
                            done_d   = 1'b0;
                            mcand_d  = {{WIDTH{1'b0}}, acc_q};
                            mplier_d = operand;
                            prod_d   = {(2*WIDTH){1'b0}};
                            cnt_d    = {CNT_W{1'b0}};
                            state_d  = S_MUL_RUN;
                        end
                        // NOP and reserved opcodes leave acc/carry untouched.
                        default: ;
                    endcase
                end
            end

            S_MUL_RUN: begin
                prod_d   = prod_next_w;
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                // Last of WIDTH iterations: commit the product this edge so the
                // result appears exactly WIDTH cycles after acceptance.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    acc_d   = prod_next_w[WIDTH-1:0];
                    carry_d = |prod_next_w[2*WIDTH-1:WIDTH];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= {WIDTH{1'b0}};
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            prod_q   <= {(2*WIDTH){1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ready   = (state_q == S_IDLE);
    assign done    = done_q;
    assign acc     = acc_q;
    assign carry   = carry_q;
    assign is_zero = (acc_q == {WIDTH{1'b0}});

endmodule
`default_nettype wire
